// File: rtl/reverb_tap_sequencer.sv
// Tap RAM plus reload sequencer: bypass the reverb, flush the FIR, stream N taps over valid/ready, then resume.
// Optional feature: define REVERB_TAP_SEQ_TIMEOUT_EN to bound the tap_done wait and report a sticky load_error.
module reverb_tap_sequencer #(
  parameter int G_TAP_WIDTH      = 16,
  parameter int G_NUM_TAPS_LOG2  = 4,
  parameter int G_SETTLE_CYCLES  = 4,
  parameter int G_TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_wr_en,
  input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
  input  logic                       load_start,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_error,
  output logic                       fir_enable,
  output logic                       fir_bypass,
  output logic [G_TAP_WIDTH-1:0]     tap_dout,
  output logic                       tap_dout_valid,
  input  logic                       tap_dout_ready,
  input  logic                       tap_done
);

  localparam int NUM_TAPS = 1 << G_NUM_TAPS_LOG2;
  localparam int CNT_MAX  = (G_TIMEOUT_CYCLES > G_SETTLE_CYCLES) ? G_TIMEOUT_CYCLES : G_SETTLE_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]           SETTLE_LAST = CNT_W'(G_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]           FLUSH_LAST  = CNT_W'(1);
  localparam logic [G_NUM_TAPS_LOG2-1:0] IDX_LAST    = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FLUSH,
    STREAM,
    WAIT_DONE,
    RESUME,
    FAULT
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [G_NUM_TAPS_LOG2-1:0] idx_q, idx_d;
  logic                       bypass_q, bypass_d;
  logic                       error_q, error_d;
  logic                       handshake;
  logic                       timeout_hit;

  logic [G_TAP_WIDTH-1:0] mem [NUM_TAPS];

  assign handshake = (state_q == STREAM) && tap_dout_ready;

`ifdef REVERB_TAP_SEQ_TIMEOUT_EN
  assign timeout_hit = (cnt_q == CNT_W'(G_TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // The RAM is only writable while idle and is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && cfg_wr_en) begin
      mem[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      bypass_q <= 1'b1;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bypass_q <= bypass_d;
      error_q  <= error_d;
    end
  end

  // Bypass and error are registered on the transition so they are already valid in the state they describe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bypass_d = bypass_q;
    error_d  = error_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = SETTLE;
          cnt_d    = '0;
          idx_d    = '0;
          bypass_d = 1'b1;
          error_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (idx_q == IDX_LAST) begin
            state_d = WAIT_DONE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (tap_done) begin
          state_d  = RESUME;
          bypass_d = 1'b0;
        end else if (timeout_hit) begin
          state_d = FAULT;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESUME: begin
        state_d = IDLE;
      end
      FAULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    load_busy      = (state_q != IDLE);
    load_done      = (state_q == RESUME);
    fir_enable     = (state_q != FLUSH);
    tap_dout_valid = (state_q == STREAM);
    fir_bypass     = bypass_q;
    load_error     = error_q;
    tap_dout       = '0;
    if (state_q == STREAM) begin
      tap_dout = mem[idx_q];
    end
  end

endmodule

// File: tb/tb_reverb_tap_sequencer.sv
// Directed bench for reverb_tap_sequencer: a vector table for the basic reload plus hand sequences for corners.
// Timeout checks are compiled only when REVERB_TAP_SEQ_TIMEOUT_EN is defined.
module tb_reverb_tap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic        load_start;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic        fir_enable;
  logic        fir_bypass;
  logic [15:0] tap_dout;
  logic        tap_dout_valid;
  logic        tap_dout_ready;
  logic        tap_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [16];

  typedef struct {
    logic        ls;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        rdy;
    logic        tdone;
    logic        busy;
    logic        done;
    logic        err;
    logic        en;
    logic        byp;
    logic        valid;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  reverb_tap_sequencer #(
    .G_TAP_WIDTH      (16),
    .G_NUM_TAPS_LOG2  (4),
    .G_SETTLE_CYCLES  (4),
    .G_TIMEOUT_CYCLES (1024)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_data    (cfg_wr_data),
    .load_start     (load_start),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_error     (load_error),
    .fir_enable     (fir_enable),
    .fir_bypass     (fir_bypass),
    .tap_dout       (tap_dout),
    .tap_dout_valid (tap_dout_valid),
    .tap_dout_ready (tap_dout_ready),
    .tap_done       (tap_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic ls, input logic we, input logic [3:0] wa,
                                 input logic [15:0] wd, input logic rdy, input logic tdone,
                                 input logic busy, input logic done, input logic err,
                                 input logic en, input logic byp, input logic valid,
                                 input logic [15:0] dout);
    vec_t v;
    v.ls = ls; v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy; v.tdone = tdone;
    v.busy = busy; v.done = done; v.err = err; v.en = en; v.byp = byp;
    v.valid = valid; v.dout = dout;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    load_start     = v.ls;
    cfg_wr_en      = v.we;
    cfg_wr_addr    = v.wa;
    cfg_wr_data    = v.wd;
    tap_dout_ready = v.rdy;
    tap_done       = v.tdone;
  endtask

  task automatic checkOutput(input int i, input vec_t v);
    check($sformatf("vec%0d_busy", i), 32'(load_busy), 32'(v.busy));
    check($sformatf("vec%0d_done", i), 32'(load_done), 32'(v.done));
    check($sformatf("vec%0d_err", i), 32'(load_error), 32'(v.err));
    check($sformatf("vec%0d_en", i), 32'(fir_enable), 32'(v.en));
    check($sformatf("vec%0d_byp", i), 32'(fir_bypass), 32'(v.byp));
    check($sformatf("vec%0d_valid", i), 32'(tap_dout_valid), 32'(v.valid));
    check($sformatf("vec%0d_dout", i), 32'(tap_dout), 32'(v.dout));
  endtask

  task automatic clearInputs();
    load_start  = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    tap_done    = 1'b0;
  endtask

  task automatic startLoad();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("start_busy", 32'(load_busy), 32'd1);
    check("start_err_clear", 32'(load_error), 32'd0);
    check("start_bypass", 32'(fir_bypass), 32'd1);
  endtask

  task automatic waitValid();
    int n = 0;
    while (!tap_dout_valid && n < 20) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(tap_dout_valid), 32'd1);
  endtask

  // mode 0: ready held high; mode 1: ready toggles 1/0 each cycle.
  task automatic streamTaps(input int mode, input int stopAt, input bit inject);
    int  hs = 0;
    int  cyc = 0;
    bit  injected = 1'b0;
    logic rdyv;
    while (hs < stopAt && cyc < 200) begin
      rdyv = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      tap_dout_ready = rdyv;
      if (inject && !injected && hs == 3) begin
        injected    = 1'b1;
        load_start  = 1'b1;
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 4'd5;
        cfg_wr_data = 16'hDEAD;
      end
      check($sformatf("tap%0d", hs), {15'd0, tap_dout_valid, tap_dout}, {15'd0, 1'b1, model[hs]});
      if (rdyv) hs++;
      tick();
      load_start = 1'b0;
      cfg_wr_en  = 1'b0;
      cyc++;
    end
    check("handshake_count", 32'(hs), 32'(stopAt));
    if (stopAt == 16) begin
      tap_dout_ready = 1'b0;
      check("valid_after_last", 32'(tap_dout_valid), 32'd0);
      check("wait_done_busy", 32'(load_busy), 32'd1);
    end
  endtask

  task automatic finishLoad();
    tap_done = 1'b1;
    tick();
    tap_done = 1'b0;
    check("resume_done", 32'(load_done), 32'd1);
    check("resume_bypass", 32'(fir_bypass), 32'd0);
    tick();
    check("idle_done_low", 32'(load_done), 32'd0);
    check("idle_busy", 32'(load_busy), 32'd0);
    check("idle_bypass_held", 32'(fir_bypass), 32'd0);
  endtask

  initial begin
    clearInputs();
    tap_dout_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    check("rst_valid", 32'(tap_dout_valid), 32'd0);
    check("rst_dout", 32'(tap_dout), 32'd0);
    check("rst_en", 32'(fir_enable), 32'd1);
    check("rst_byp", 32'(fir_bypass), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mkVec(1'b0, 1'b1, 4'(i), 16'(i + 1), 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0));
      model[i] = 16'(i + 1);
    end
    vecs.push_back(mkVec(1'b1, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0,
                         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkVec(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mkVec(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mkVec(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'(k + 1)));
    vecs.push_back(mkVec(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0,
                         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0));
    vecs.push_back(mkVec(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0,
                         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0));
    vecs.push_back(mkVec(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1,
                         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mkVec(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mkVec(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(i, vecs[i]);
    end
    clearInputs();
    tap_dout_ready = 1'b0;

    // Ready toggling: every tap must hold while stalled and arrive exactly once.
    startLoad();
    waitValid();
    streamTaps(1, 16, 1'b0);
    finishLoad();

    // load_start and a RAM write during STREAM must both be ignored.
    startLoad();
    waitValid();
    streamTaps(0, 16, 1'b1);
`ifdef REVERB_TAP_SEQ_TIMEOUT_EN
    begin
      int n = 1;
      while (!load_error && n < 1100) begin
        tick();
        n++;
      end
      check("timeout_cycles", 32'(n), 32'd1025);
      check("fault_busy", 32'(load_busy), 32'd1);
      check("fault_byp", 32'(fir_bypass), 32'd1);
      tick();
      check("post_fault_idle", 32'(load_busy), 32'd0);
      check("post_fault_err", 32'(load_error), 32'd1);
      check("post_fault_byp", 32'(fir_bypass), 32'd1);
      startLoad();
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
`else
    for (int i = 0; i < 1100; i++) tick();
    check("no_timeout_busy", 32'(load_busy), 32'd1);
    check("no_timeout_err", 32'(load_error), 32'd0);
    finishLoad();
    tick();
    check("no_second_load", 32'(load_busy), 32'd0);
`endif

    // Reset in the middle of streaming, at idx 7.
    startLoad();
    waitValid();
    streamTaps(0, 7, 1'b0);
    check("idx7_dout", {15'd0, tap_dout_valid, tap_dout}, {15'd0, 1'b1, model[7]});
    tap_dout_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(tap_dout_valid), 32'd0);
    check("midrst_busy", 32'(load_busy), 32'd0);
    check("midrst_byp", 32'(fir_bypass), 32'd1);
    check("midrst_dout", 32'(tap_dout), 32'd0);
    tick();
    check("midrst_no_more_taps", 32'(tap_dout_valid), 32'd0);
    tap_dout_ready = 1'b0;

    // Write and load_start in the same idle cycle: the new tap 3 must be streamed.
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 4'd3;
    cfg_wr_data = 16'hABCD;
    model[3]    = 16'hABCD;
    startLoad();
    cfg_wr_en = 1'b0;
    waitValid();
    streamTaps(0, 16, 1'b0);
    finishLoad();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
